mem_access_unit: RTL

Initiator side of the RAM request/response interface: the load/store stage of the core. Takes one decoded RV32I load/store per request, checks alignment and address range, issues a single-cycle request to RAM, waits for operationOK, then sign/zero-extends load data and returns one result pulse. Sits between the execute stage and the RAM.

---
 rtl/mem_access_unit_pkg.sv | 63 ++++++
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit_load_extend.sv | 22 ++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, types and helpers for the load/store unit.
// Exception codes and memory widths match the RAM side of the interface.
package mem_access_unit_pkg;

  localparam int EXCEPTION_LEN = 4;
  typedef logic [EXCEPTION_LEN-1:0] excep_t;

  localparam excep_t EXCEP_OK                = 4'd0;
  localparam excep_t EXCEP_INVALID_MEM_READ  = 4'd1;
  localparam excep_t EXCEP_INVALID_MEM_WRITE = 4'd2;
  localparam excep_t EXCEP_MISALIGNED_LOAD   = 4'd3;
  localparam excep_t EXCEP_MISALIGNED_STORE  = 4'd4;
  localparam excep_t EXCEP_MEM_TIMEOUT       = 4'd5;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  localparam logic [1:0] LSU_IDLE  = 2'd0;
  localparam logic [1:0] LSU_ISSUE = 2'd1;
  localparam logic [1:0] LSU_WAIT  = 2'd2;
  localparam logic [1:0] LSU_DONE  = 2'd3;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
  } mem_req_t;

  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    return f3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] a);
    case (width)
      MEM_WIDTH_HALF: return a[0];
      MEM_WIDTH_WORD: return |a;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] trim_store_data(input logic [1:0] width,
                                                  input logic [31:0] data);
    case (width)
      MEM_WIDTH_BYTE: return {24'd0, data[7:0]};
      MEM_WIDTH_HALF: return {16'd0, data[15:0]};
      default:        return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/result bus from the execute stage plus the RAM request bus.
// slave = the load/store unit, master = execute stage and RAM together.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic        reqValid_In;
  logic        reqReady_Out;
  logic        isLoad_In;
  logic [2:0]  funct3_In;
  logic [31:0] addr_In;
  logic [31:0] storeData_In;
  logic        resultValid_Out;
  logic [31:0] loadData_Out;
  excep_t      exception_Out;

  logic [31:0] ramAddr_Out;
  logic [31:0] ramData_Out;
  logic [1:0]  ramWidth_Out;
  logic        ramIsRead_Out;
  logic        ramValid_Out;
  logic [31:0] ramData_In;
  logic        ramOK_In;
  excep_t      ramException_In;

  modport slave (
    input  reqValid_In, isLoad_In, funct3_In, addr_In, storeData_In,
    input  ramData_In, ramOK_In, ramException_In,
    output reqReady_Out, resultValid_Out, loadData_Out, exception_Out,
    output ramAddr_Out, ramData_Out, ramWidth_Out, ramIsRead_Out, ramValid_Out
  );

  modport master (
    output reqValid_In, isLoad_In, funct3_In, addr_In, storeData_In,
    output ramData_In, ramOK_In, ramException_In,
    input  reqReady_Out, resultValid_Out, loadData_Out, exception_Out,
    input  ramAddr_Out, ramData_Out, ramWidth_Out, ramIsRead_Out, ramValid_Out
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of raw RAM read data according to the load funct3.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
  always_comb begin
    ext = raw;
    case (funct3)
      FUNCT3_LB:  ext = {{24{raw[7]}}, raw[7:0]};
      FUNCT3_LH:  ext = {{16{raw[15]}}, raw[15:0]};
      FUNCT3_LBU: ext = {24'd0, raw[7:0]};
      FUNCT3_LHU: ext = {16'd0, raw[15:0]};
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: validates a request, runs one RAM transaction with a
// timeout, and returns a single-cycle result pulse with extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_BITS      = 29,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  mem_req_t         req_q, req_d;
  excep_t           ram_exc_q, ram_exc_d;
  excep_t           exc_q, exc_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] ext_data;
  logic        out_of_range;
  logic        bad_funct3;

  mem_access_unit_load_extend u_load_extend (
    .funct3 (req_q.funct3),
    .raw    (bus.ramData_In),
    .ext    (ext_data)
  );

  assign out_of_range = |(bus.addr_In >> ADDR_BITS);
  assign bad_funct3   = !funct3_legal(bus.isLoad_In, bus.funct3_In);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ram_exc_d   = ram_exc_q;
    exc_d       = exc_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;

    case (state_q)
      LSU_IDLE: begin
        if (bus.reqValid_In) begin
          req_d       = '{is_load: bus.isLoad_In, funct3: bus.funct3_In,
                          addr: bus.addr_In, store_data: bus.storeData_In};
          load_data_d = '0;
          cnt_d       = '0;
          // Range/encoding errors take priority over alignment errors.
          if (bad_funct3 || out_of_range) begin
            state_d = LSU_DONE;
            exc_d   = bus.isLoad_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
          end else if (is_misaligned(bus.funct3_In[1:0], bus.addr_In[1:0])) begin
            state_d = LSU_DONE;
            exc_d   = bus.isLoad_In ? EXCEP_MISALIGNED_LOAD : EXCEP_MISALIGNED_STORE;
          end else begin
            state_d = LSU_ISSUE;
            exc_d   = EXCEP_OK;
          end
        end
      end
      LSU_ISSUE: begin
        ram_exc_d = bus.ramException_In;
        cnt_d     = '0;
        state_d   = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (bus.ramOK_In) begin
          state_d = LSU_DONE;
          if (ram_exc_q != EXCEP_OK) begin
            exc_d       = ram_exc_q;
            load_data_d = '0;
          end else begin
            exc_d       = EXCEP_OK;
            load_data_d = req_q.is_load ? ext_data : '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = LSU_DONE;
          exc_d       = EXCEP_MEM_TIMEOUT;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LSU_IDLE;
      req_q       <= '0;
      ram_exc_q   <= EXCEP_OK;
      exc_q       <= EXCEP_OK;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ram_exc_q   <= ram_exc_d;
      exc_q       <= exc_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Handshake outputs are gated by rst so they drop in the same cycle reset asserts.
  assign bus.reqReady_Out    = rst && (state_q == LSU_IDLE);
  assign bus.ramValid_Out    = rst && (state_q == LSU_ISSUE);
  assign bus.resultValid_Out = rst && (state_q == LSU_DONE);
  assign bus.loadData_Out    = load_data_q;
  assign bus.exception_Out   = exc_q;

  assign bus.ramAddr_Out   = req_q.addr;
  assign bus.ramWidth_Out  = req_q.funct3[1:0];
  assign bus.ramIsRead_Out = req_q.is_load;
  assign bus.ramData_Out   = trim_store_data(req_q.funct3[1:0], req_q.store_data);

endmodule
